instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Sequential instruction fetch front end; producer of op/func for the single-cycle control decoder.
- Holds the PC and fetches 32-bit words from instruction memory over a req/ack handshake.
- Presents each instruction with a valid/ready handshake; applies beq redirects at instruction accept.
- Sits between instruction memory and the control decoder/datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TIMEOUT, 16, max cycles imem_req may wait for imem_ack before error (range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- imem_addr  output  32  fetch address (= pc while imem_req=1).
- imem_req  output  1  fetch request.
- imem_ack  input  1  memory response; imem_rdata valid in the same cycle.
- imem_rdata  input  32  fetched word.
- instr  output  32  captured instruction.
- op  output  6  instr[31:26], to control decoder.
- func  output  6  instr[5:0], to control decoder.
- instr_valid  output  1  instr/op/func valid.
- instr_ready  input  1  downstream accepts the current instruction.
- take_branch  input  1  Branch AND ALU zero for the current instruction; sampled only at accept.
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  pc + 4 (combinational).
- fetch_err  output  1  sticky ack-timeout flag.

Behaviour:
- One clock, clk. Reset asynchronous and active-high on rst; it overrides everything in any state.
- Reset values: pc=RESET_PC, instr=0 (op=0, func=0), instr_valid=0, imem_req=0, imem_addr=RESET_PC, fetch_err=0, state=IDLE, wait counter=0.
- States: IDLE, REQ, VALID, ERR.
- IDLE: first clk edge after rst deasserts -> REQ. No request is issued in IDLE.
- REQ:
  - imem_req=1, imem_addr=pc, both held stable until ack.
  - On an edge with imem_ack=1: instr<=imem_rdata, counter cleared, go to VALID.
  - Same-cycle ack is legal; minimum fetch latency is 1 cycle from req to instr_valid.
  - Without ack: counter increments each cycle.
  - If counter reaches TIMEOUT-1 with imem_ack=0: go to ERR, fetch_err<=1.
- VALID:
  - instr_valid=1, imem_req=0; instr/op/func/pc stable until accept.
  - Accept is an edge with instr_valid=1 and instr_ready=1.
  - At accept, pc<=pc_plus4 + {sext(instr[15:0]),2'b00} if take_branch=1, else pc<=pc_plus4; go to REQ.
  - instr_valid drops for at least one cycle between instructions; throughput is at most 1 instruction / 2 cycles.
  - take_branch is ignored outside accept.
- ERR: instr_valid=0, imem_req=0, fetch_err=1; exit only via rst.
- Arithmetic: 32-bit, modulo 2^32.
  - pc=32'hFFFF_FFFC with no branch wraps to 0.
  - Negative offsets sign-extend; offset 16'hFFFF yields target = pc.
- op and func are pure slices of instr, registered with it; no decode in this block.
- Reset mid-fetch: request withdrawn immediately, asynchronously. A late ack while in IDLE is ignored.
- imem_ack outside REQ is ignored.

Test Plan:
- Reset release, RESET_PC=0, memory acks next cycle, instr_ready=1 -> imem_addr sequence 0,4,8; instr_valid pulses alternate cycles; op/func match the words.
- Word 32'h0000_0020 (add) at 0 -> op=6'b000000, func=6'b100000; pc=0 held while instr_ready=0 for 5 cycles; instr unchanged.
- beq 32'h1000_0003 at pc=8, take_branch=1 at accept -> next imem_addr=0x18. Same word with take_branch=0 -> 0x0C.
- beq offset 16'hFFFE at pc=0x20, take_branch=1 -> next imem_addr=0x1C. pc=0xFFFF_FFFC, no branch -> next imem_addr=0.
- imem_ack held low, TIMEOUT=16 -> fetch_err=1 after 16 request cycles; imem_req=0; state sticks until rst.
- rst asserted mid-REQ with imem_addr=0x40 -> imem_req=0 and pc=RESET_PC with no clock edge; ack during reset ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch front end: holds the PC, fetches words over a req/ack
// handshake, and presents them downstream on a valid/ready handshake with beq redirects.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        take_branch,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, REQ, VALID, ERR} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [31:0] branch_off;

    // The PC only moves at accept, so it doubles as the stable fetch address.
    assign imem_addr  = pc;
    assign pc_plus4   = pc + 32'd4;
    assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign op         = instr[31:26];
    assign func       = instr[5:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    imem_req <= 1'b1;
                    wait_cnt <= '0;
                    state    <= REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        wait_cnt    <= '0;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= VALID;
                    end else if (wait_cnt == WAIT_LAST) begin
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                        state     <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                VALID: begin
                    if (instr_ready) begin
                        pc          <= take_branch ? (pc_plus4 + branch_off) : pc_plus4;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end
                end
                ERR: begin
                    // Sticky until reset.
                    instr_valid <= 1'b0;
                    imem_req    <= 1'b0;
                    fetch_err   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a table-driven program walk with a fetch scoreboard,
// plus hand sequences for ready stall, ack timeout and asynchronous reset mid-fetch.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        instr_valid;
    logic        instr_ready;
    logic        take_branch;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .op(op), .func(func),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .take_branch(take_branch), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        take;
        logic [31:0] nxt;
        int          dly;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    localparam int NV = 14;
    vec_t tbl [NV];
    exp_t sb [$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] w = 32'hDEAD_BEEF;
        for (int k = 0; k < NV; k++)
            if (tbl[k].pc == a) w = tbl[k].word;
        return w;
    endfunction

    // One fetch/accept round for table entry i; hold stalls the accept 5 cycles.
    task automatic do_fetch(input int i, input bit hold);
        int   n = 0;
        exp_t e;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("req_wait_timeout", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, tbl[i].pc);
        repeat (tbl[i].dly) begin
            @(negedge clk);
            chk("req_held", {imem_req, imem_addr[30:0]}, {1'b1, tbl[i].pc[30:0]});
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_rd(imem_addr);
        sb.push_back('{pc: tbl[i].pc, word: tbl[i].word});
        @(negedge clk);
        imem_ack = 1'b0;
        chk("valid_after_ack", 32'(instr_valid), 32'd1);
        chk("req_drop_after_ack", 32'(imem_req), 32'd0);
        if (hold) begin
            instr_ready = 1'b0;
            take_branch = 1'b1;
            repeat (5) begin
                @(negedge clk);
                chk("stall_valid", 32'(instr_valid), 32'd1);
                chk("stall_pc", pc, tbl[i].pc);
                chk("stall_instr", instr, tbl[i].word);
            end
            take_branch = 1'b0;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("pc", pc, e.pc);
            chk("instr", instr, e.word);
            chk("op", 32'(op), 32'(e.word[31:26]));
            chk("func", 32'(func), 32'(e.word[5:0]));
            chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        end
        instr_ready = 1'b1;
        take_branch = tbl[i].take;
        @(negedge clk);
        instr_ready = 1'b0;
        take_branch = 1'b0;
        chk("next_pc", pc, tbl[i].nxt);
        chk("valid_gap", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        int cnt;
        tbl[0]  = '{32'h0000_0000, 32'h0000_0020, 1'b0, 32'h0000_0004, 0};
        tbl[1]  = '{32'h0000_0004, 32'h0000_0022, 1'b0, 32'h0000_0008, 0};
        tbl[2]  = '{32'h0000_0008, 32'h1000_0003, 1'b0, 32'h0000_000C, 0};
        tbl[3]  = '{32'h0000_000C, 32'h1000_FFFF, 1'b1, 32'h0000_000C, 1};
        tbl[4]  = '{32'h0000_000C, 32'h1000_FFFF, 1'b0, 32'h0000_0010, 2};
        tbl[5]  = '{32'h0000_0010, 32'h1000_FFFA, 1'b1, 32'hFFFF_FFFC, 0};
        tbl[6]  = '{32'hFFFF_FFFC, 32'h8C01_0004, 1'b0, 32'h0000_0000, 1};
        tbl[7]  = '{32'h0000_0000, 32'h0000_0020, 1'b0, 32'h0000_0004, 0};
        tbl[8]  = '{32'h0000_0004, 32'h0000_0022, 1'b0, 32'h0000_0008, 2};
        tbl[9]  = '{32'h0000_0008, 32'h1000_0003, 1'b1, 32'h0000_0018, 0};
        tbl[10] = '{32'h0000_0018, 32'h1000_0001, 1'b1, 32'h0000_0020, 1};
        tbl[11] = '{32'h0000_0020, 32'h1000_FFFE, 1'b1, 32'h0000_001C, 0};
        tbl[12] = '{32'h0000_001C, 32'h1000_FFFA, 1'b1, 32'h0000_0008, 2};
        tbl[13] = '{32'h0000_0008, 32'h1000_0003, 1'b0, 32'h0000_000C, 0};

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; take_branch = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_op_func", {20'h0, op, func}, 32'h0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) do_fetch(i, i == 0);

        // Ack never arrives: error after TIMEOUT request cycles, then sticky.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (imem_req) cnt++;
        end
        chk("timeout_req_cycles", 32'(cnt), 32'd16);
        chk("timeout_err", 32'(fetch_err), 32'd1);
        chk("timeout_req_low", 32'(imem_req), 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        chk("err_sticky", {fetch_err, imem_req, instr_valid}, 3'b100);

        // Reset in the middle of a request, with a late ack during reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_fetch(0, 1'b0);
        do_fetch(1, 1'b0);
        chk("midreq_addr", imem_addr, 32'h8);
        chk("midreq_req", 32'(imem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_req_drop", 32'(imem_req), 32'd0);
        chk("async_pc", pc, 32'h0);
        chk("async_addr", imem_addr, 32'h0);
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0020;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ack_ignored", {instr_valid, instr}, 33'h0);
        chk("restart_req", {imem_req, imem_addr}, {1'b1, 32'h0});
        @(negedge clk);
        imem_ack = 1'b0;
        chk("restart_valid", 32'(instr_valid), 32'd1);
        chk("restart_instr", instr, 32'h0000_0020);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
